// File: rtl/led_status_arbiter.sv
// rtl/led_status_arbiter.sv - fixed-priority owner of the RGB status LED with min hold and blink timing
module led_status_arbiter #(
    parameter int TICK_CYCLES    = 12_000,
    parameter int MIN_HOLD_TICKS = 500,
    parameter int HALF_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [2:0]        color0,
    input  logic [2:0]        color1,
    input  logic [2:0]        color2,
    input  logic [HALF_W-1:0] half0,
    input  logic [HALF_W-1:0] half1,
    input  logic [HALF_W-1:0] half2,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              LED_R,
    output logic              LED_G,
    output logic              LED_B
);

    localparam int PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HOLD_W = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_TICKS);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state, state_next;
    logic [PRE_W-1:0]  presc, presc_next;
    logic [HALF_W-1:0] phase, phase_next;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
    logic [2:0]        color_l, color_l_next;
    logic [HALF_W-1:0] half_l, half_l_next;
    logic              led_on, led_on_next;
    logic [2:0]        grant_next;
    logic              busy_next;
    logic              led_r_next, led_g_next, led_b_next;

    logic              tick;
    logic              hold_done;
    logic              rearb;
    logic [2:0]        winner;
    logic [2:0]        win_color;
    logic [HALF_W-1:0] win_half;

    function automatic logic [2:0] pick_highest(input logic [2:0] r);
        if (r[2])      return 3'b100;
        else if (r[1]) return 3'b010;
        else if (r[0]) return 3'b001;
        else           return 3'b000;
    endfunction

    function automatic logic [2:0] higher_than(input logic [2:0] g);
        case (g)
            3'b001:  return 3'b110;
            3'b010:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        winner    = pick_highest(req);
        win_color = 3'b000;
        win_half  = '0;
        case (winner)
            3'b100: begin win_color = color2; win_half = half2; end
            3'b010: begin win_color = color1; win_half = half1; end
            3'b001: begin win_color = color0; win_half = half0; end
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state;
        presc_next    = presc;
        phase_next    = phase;
        hold_cnt_next = hold_cnt;
        color_l_next  = color_l;
        half_l_next   = half_l;
        led_on_next   = led_on;
        grant_next    = grant;
        busy_next     = busy;

        tick  = (state == OWN) && (presc == PRE_MAX);
        // Switch when a higher requester waits, or the owner has let go and someone else waits
        rearb = ((req & higher_than(grant)) != 3'b000) ||
                (((req & grant) == 3'b000) && (req != 3'b000));

        // Hold is judged on the post-tick count so release lands on the expiring tick edge
        if (tick && (hold_cnt != HOLD_MAX))
            hold_cnt_next = hold_cnt + 1'b1;
        hold_done = (hold_cnt_next == HOLD_MAX);

        case (state)
            IDLE: begin
                if (req != 3'b000) begin
                    state_next    = OWN;
                    grant_next    = winner;
                    busy_next     = 1'b1;
                    color_l_next  = win_color;
                    half_l_next   = win_half;
                    led_on_next   = 1'b1;
                    presc_next    = '0;
                    phase_next    = '0;
                    hold_cnt_next = '0;
                end
            end
            OWN: begin
                presc_next = tick ? '0 : presc + 1'b1;
                if (tick && (half_l != '0)) begin
                    if (phase == half_l - 1'b1) begin
                        led_on_next = ~led_on;
                        phase_next  = '0;
                    end else begin
                        phase_next  = phase + 1'b1;
                    end
                end
                if (hold_done) begin
                    if (req == 3'b000) begin
                        state_next    = IDLE;
                        grant_next    = 3'b000;
                        busy_next     = 1'b0;
                        color_l_next  = 3'b000;
                        half_l_next   = '0;
                        led_on_next   = 1'b0;
                        presc_next    = '0;
                        phase_next    = '0;
                        hold_cnt_next = '0;
                    end else if (rearb) begin
                        grant_next    = winner;
                        color_l_next  = win_color;
                        half_l_next   = win_half;
                        led_on_next   = 1'b1;
                        presc_next    = '0;
                        phase_next    = '0;
                        hold_cnt_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        led_r_next = ~(led_on_next & color_l_next[2]);
        led_g_next = ~(led_on_next & color_l_next[1]);
        led_b_next = ~(led_on_next & color_l_next[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            phase    <= '0;
            hold_cnt <= '0;
            color_l  <= 3'b000;
            half_l   <= '0;
            led_on   <= 1'b0;
            grant    <= 3'b000;
            busy     <= 1'b0;
            LED_R    <= 1'b1;
            LED_G    <= 1'b1;
            LED_B    <= 1'b1;
        end else begin
            state    <= state_next;
            presc    <= presc_next;
            phase    <= phase_next;
            hold_cnt <= hold_cnt_next;
            color_l  <= color_l_next;
            half_l   <= half_l_next;
            led_on   <= led_on_next;
            grant    <= grant_next;
            busy     <= busy_next;
            LED_R    <= led_r_next;
            LED_G    <= led_g_next;
            LED_B    <= led_b_next;
        end
    end

endmodule

// File: tb/tb_led_status_arbiter.sv
// tb/tb_led_status_arbiter.sv - directed bench for led_status_arbiter with short tick and hold
module tb_led_status_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  color0 = 3'b000, color1 = 3'b000, color2 = 3'b000;
    logic [15:0] half0 = 16'd0, half1 = 16'd0, half2 = 16'd0;
    logic [2:0]  grant;
    logic        busy, LED_R, LED_G, LED_B;
    int          compared = 0;
    int          mismatched = 0;

    // {grant, busy, LED_R, LED_G, LED_B}
    wire [6:0] status = {grant, busy, LED_R, LED_G, LED_B};
    localparam logic [6:0] ST_IDLE = 7'b000_0_111;

    led_status_arbiter #(
        .TICK_CYCLES(10),
        .MIN_HOLD_TICKS(5),
        .HALF_W(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .color0(color0), .color1(color1), .color2(color2),
        .half0(half0), .half1(half1), .half2(half2),
        .grant(grant), .busy(busy),
        .LED_R(LED_R), .LED_G(LED_G), .LED_B(LED_B)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        req = 3'b000;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (status !== ST_IDLE) begin
                mismatched++;
                $display("FAIL reset_hold: got %b want %b", status, ST_IDLE);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            compared++;
            if (status !== ST_IDLE) begin
                mismatched++;
                $display("FAIL idle_cycle%0d: got %b want %b", i, status, ST_IDLE);
            end
        end
    endtask

    task automatic test_single_blink;
        color0 = 3'b010; half0 = 16'd3; req = 3'b001;
        @(negedge clk);
        compared++;
        if (status !== 7'b001_1_101) begin
            mismatched++;
            $display("FAIL blink_grant: got %b want %b", status, 7'b001_1_101);
        end
        repeat (29) @(negedge clk);
        compared++;
        if (status !== 7'b001_1_101) begin
            mismatched++;
            $display("FAIL blink_pre30: got %b want %b", status, 7'b001_1_101);
        end
        @(negedge clk);
        compared++;
        if (status !== 7'b001_1_111) begin
            mismatched++;
            $display("FAIL blink_off30: got %b want %b", status, 7'b001_1_111);
        end
        repeat (30) @(negedge clk);
        compared++;
        if (status !== 7'b001_1_101) begin
            mismatched++;
            $display("FAIL blink_on60: got %b want %b", status, 7'b001_1_101);
        end
        repeat (30) @(negedge clk);
        compared++;
        if (status !== 7'b001_1_111) begin
            mismatched++;
            $display("FAIL blink_off90: got %b want %b", status, 7'b001_1_111);
        end
        req = 3'b000;
        @(negedge clk);
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL blink_release: got %b want %b", status, ST_IDLE);
        end
    endtask

    task automatic test_hold;
        color0 = 3'b001; half0 = 16'd0; req = 3'b001;
        @(negedge clk);
        compared++;
        if (status !== 7'b001_1_110) begin
            mismatched++;
            $display("FAIL hold_grant: got %b want %b", status, 7'b001_1_110);
        end
        repeat (12) @(negedge clk);
        req = 3'b000;
        repeat (37) @(negedge clk);
        compared++;
        if (status !== 7'b001_1_110) begin
            mismatched++;
            $display("FAIL hold_kept49: got %b want %b", status, 7'b001_1_110);
        end
        @(negedge clk);
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL hold_release50: got %b want %b", status, ST_IDLE);
        end
    endtask

    task automatic test_preempt;
        color1 = 3'b100; half1 = 16'd0; req = 3'b010;
        @(negedge clk);
        compared++;
        if (status !== 7'b010_1_011) begin
            mismatched++;
            $display("FAIL preempt_run_grant: got %b want %b", status, 7'b010_1_011);
        end
        repeat (20) @(negedge clk);
        color2 = 3'b111; half2 = 16'd0; req = 3'b110;
        color1 = 3'b001;
        repeat (29) @(negedge clk);
        compared++;
        if (status !== 7'b010_1_011) begin
            mismatched++;
            $display("FAIL preempt_wait49: got %b want %b", status, 7'b010_1_011);
        end
        @(negedge clk);
        compared++;
        if (status !== 7'b100_1_000) begin
            mismatched++;
            $display("FAIL preempt_switch50: got %b want %b", status, 7'b100_1_000);
        end
        req = 3'b000;
        repeat (60) @(negedge clk);
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL preempt_cleanup: got %b want %b", status, ST_IDLE);
        end
    endtask

    task automatic test_back_to_back;
        color2 = 3'b111; half2 = 16'd0;
        color1 = 3'b010; half1 = 16'd2;
        color0 = 3'b001; half0 = 16'd0;
        req = 3'b111;
        @(negedge clk);
        compared++;
        if (status !== 7'b100_1_000) begin
            mismatched++;
            $display("FAIL prio_fault_first: got %b want %b", status, 7'b100_1_000);
        end
        repeat (55) @(negedge clk);
        req = 3'b011;
        @(negedge clk);
        compared++;
        if (status !== 7'b010_1_101) begin
            mismatched++;
            $display("FAIL prio_handover: got %b want %b", status, 7'b010_1_101);
        end
        repeat (19) @(negedge clk);
        compared++;
        if (status !== 7'b010_1_101) begin
            mismatched++;
            $display("FAIL prio_pre20: got %b want %b", status, 7'b010_1_101);
        end
        @(negedge clk);
        compared++;
        if (status !== 7'b010_1_111) begin
            mismatched++;
            $display("FAIL prio_off20: got %b want %b", status, 7'b010_1_111);
        end
        repeat (40) @(negedge clk);
        compared++;
        if (status !== 7'b010_1_111) begin
            mismatched++;
            $display("FAIL prio_no_lower_preempt: got %b want %b", status, 7'b010_1_111);
        end
        req = 3'b000;
        @(negedge clk);
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL prio_release: got %b want %b", status, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid;
        color1 = 3'b110; half1 = 16'd0; req = 3'b010;
        @(negedge clk);
        compared++;
        if (status !== 7'b010_1_001) begin
            mismatched++;
            $display("FAIL rstmid_grant: got %b want %b", status, 7'b010_1_001);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (status !== ST_IDLE) begin
            mismatched++;
            $display("FAIL rstmid_clear: got %b want %b", status, ST_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (status !== 7'b010_1_001) begin
            mismatched++;
            $display("FAIL rstmid_regrant: got %b want %b", status, 7'b010_1_001);
        end
        req = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single_blink();
        test_hold();
        test_preempt();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/led_status_arbiter.md
Name: led_status_arbiter

Overview:
- Shares the iCESugar RGB LED (active-low pins) between three status requesters: fault, run and heartbeat.
- Each requester asks for the LED with its own colour and blink half-period.
- The block grants the LED by fixed priority, enforces a minimum visible hold time, and generates the blink timing from the 12 MHz board clock.
- Sits between status logic and the top-level LED_R/LED_G/LED_B pins.

Parameters:
- TICK_CYCLES, 12_000: clk cycles per timing tick (1 ms at 12 MHz).
- MIN_HOLD_TICKS, 500: minimum ticks a grant is held before re-arbitration.
- HALF_W, 16: width of the per-requester half-period inputs, in ticks.

Ports:
- clk  in  1  board clock, 12 MHz.
- rst  in  1  synchronous, active-high reset.
- req  in  3  request lines; req[2] fault (highest priority), req[1] run, req[0] heartbeat (lowest).
- color0  in  3  {R,G,B} colour for requester 0, active-high.
- color1  in  3  colour for requester 1.
- color2  in  3  colour for requester 2.
- half0  in  HALF_W  blink half-period for requester 0, in ticks; 0 = solid on.
- half1  in  HALF_W  same, requester 1.
- half2  in  HALF_W  same, requester 2.
- grant  out  3  one-hot current owner; all zero when idle.
- busy  out  1  high while any grant is active.
- LED_R  out  1  red pin, active-low.
- LED_G  out  1  green pin, active-low.
- LED_B  out  1  blue pin, active-low.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - On rst: state=IDLE, grant=0, busy=0, LED_R/G/B=1 (off), all counters 0, latched colour 0, led_on=0.
  - Reset asserted mid-blink overrides everything on that edge.
- Outputs are registered. LED_x = ~(led_on & latched_colour_bit).
- IDLE state:
  - LEDs off.
  - If req!=0 at edge N: at edge N grant takes the highest set bit (one-hot) and busy=1.
  - On the same edge: colorK/halfK of the winner are latched, led_on=1, and prescaler, phase and hold counters are cleared.
  - Grant and LEDs are therefore visible one cycle after req is sampled high.
- OWN state, tick generation:
  - Prescaler counts 0..TICK_CYCLES-1 and emits a one-cycle tick when it wraps.
  - The first tick is TICK_CYCLES cycles after the grant edge.
- OWN state, blinking:
  - When latched half=0: led_on stays 1.
  - When latched half>0: on each tick the phase counter increments. When phase==half-1 on a tick, led_on toggles and phase clears.
  - First off-edge is half ticks after the grant.
- OWN state, hold and colour latching:
  - The hold counter increments on each tick and saturates at MIN_HOLD_TICKS; hold_done = (hold_cnt==MIN_HOLD_TICKS).
  - Latched colour and half are not affected by input changes while owned.
- Re-arbitration happens only when hold_done=1, evaluated every cycle:
  - Owner's req low and other reqs pending: grant the highest pending and re-latch it as in IDLE (no gap cycle).
  - Higher-priority req high: preempt to it with the same re-latch.
  - Owner's req low and no other req: go to IDLE, grant=0, busy=0, LEDs off on that edge.
  - Otherwise keep the current owner.
- Before hold_done:
  - The owner dropping req does not release the grant; the LED keeps blinking until hold expires, then the rules above apply.
  - Higher-priority requests wait.
- Simultaneous events: owner drop and higher-priority raise in the same cycle after hold resolve to the highest pending req.
- Lower-priority requests never preempt. An equal owner re-requesting is a no-op.
- Arithmetic and widths:
  - Counters are wide enough for TICK_CYCLES-1, MIN_HOLD_TICKS and 2^HALF_W-1.
  - Phase and hold comparisons are unsigned; no wrap-around of the hold counter.
- Invariant: grant is always one-hot or zero, and busy equals |grant.

Test Plan:
Use TICK_CYCLES=10, MIN_HOLD_TICKS=5 in all scenarios.
- Reset/idle: rst held 3 cycles then released, req=0 for 100 cycles -> grant=000, busy=0, LED_R/G/B=1 throughout.
- Single grant blink: req=001, color0=010, half0=3 -> grant=001 one cycle later, LED_G=0, others 1; LED_G toggles every 30 cycles (at 30, 60, 90 after grant).
- Hold enforcement: req[0] granted, req[0] dropped after 12 cycles -> grant stays 001 until the 5th tick (cycle 50 after grant), then IDLE with LEDs=111 on that edge.
- Preemption: run (req[1], color1=100, half1=0) owns; fault req[2] (color2=111) raised at tick 2 -> grant switches to 100 exactly at the 5th tick edge, all LEDs 0 (solid on), no idle gap.
- Simultaneous/priority: req=111 from IDLE -> grant=100. After hold, drop req[2] -> grant=010 on the next edge, colour re-latched, led_on=1.
- Reset mid-operation: rst pulsed while granted with LED on -> next edge grant=000, busy=0, LEDs=111; requests then re-arbitrate normally after rst deasserts.
